// File: rtl/partition_sweep_pkg.sv
// Shared types and width helpers for the partition sweep engine.
// Optional build macro: SWEEP_TRACE_EN (adds a per-vector trace stream).
package partition_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    // One count per swept vector, plus a bit so 2^n_in itself fits.
    function automatic int err_cnt_w(input int n_in);
        return n_in + 1;
    endfunction

    // Each vector adds at most n_out differing bits.
    function automatic int ham_sum_w(input int n_in, input int n_out);
        return n_in + $clog2(n_out + 1);
    endfunction

    // Each vector adds at most 2^n_out-1.
    function automatic int abs_sum_w(input int n_in, input int n_out);
        return n_in + n_out;
    endfunction

    // Packs {pi, po_exact, po_approx}; the caller truncates to its record width.
    function automatic logic [63:0] pack_trace(input logic [31:0] pi,
                                               input logic [31:0] exact,
                                               input logic [31:0] approx,
                                               input int          n_out);
        return ({32'd0, pi} << (2 * n_out)) | ({32'd0, exact} << n_out) | {32'd0, approx};
    endfunction

endpackage

// File: rtl/partition_sweep_engine_if.sv
// Host/partition bus of the sweep engine; master = host + partition pair, slave = engine.
// Optional build macro: SWEEP_TRACE_EN (adds trc_valid/trc_ready/trc_data).
interface partition_sweep_engine_if #(
    parameter int N_IN  = 7,
    parameter int N_OUT = 4
);
    localparam int ERR_W = partition_sweep_pkg::err_cnt_w(N_IN);
    localparam int HAM_W = partition_sweep_pkg::ham_sum_w(N_IN, N_OUT);
    localparam int ABS_W = partition_sweep_pkg::abs_sum_w(N_IN, N_OUT);

    logic             start;
    logic             abort;
    logic [N_IN-1:0]  pi;
    logic [N_OUT-1:0] po_exact;
    logic [N_OUT-1:0] po_approx;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [ERR_W-1:0] err_cnt;
    logic [HAM_W-1:0] ham_sum;
    logic [ABS_W-1:0] abs_sum;
    logic [N_OUT-1:0] max_err;

`ifdef SWEEP_TRACE_EN
    logic                      trc_valid;
    logic                      trc_ready;
    logic [N_IN+2*N_OUT-1:0]   trc_data;

    modport master (output start, abort, po_exact, po_approx, trc_ready,
                    input  pi, busy, done, aborted, err_cnt, ham_sum, abs_sum, max_err,
                           trc_valid, trc_data);
    modport slave  (input  start, abort, po_exact, po_approx, trc_ready,
                    output pi, busy, done, aborted, err_cnt, ham_sum, abs_sum, max_err,
                           trc_valid, trc_data);
`else
    modport master (output start, abort, po_exact, po_approx,
                    input  pi, busy, done, aborted, err_cnt, ham_sum, abs_sum, max_err);
    modport slave  (input  start, abort, po_exact, po_approx,
                    output pi, busy, done, aborted, err_cnt, ham_sum, abs_sum, max_err);
`endif

endinterface

// File: rtl/partition_sweep_engine_popcount.sv
// Combinational population count, used for the Hamming distance of one vector.
module sweep_popcount #(
    parameter int W = 4
) (
    input  logic [W-1:0]             vec,
    output logic [$clog2(W+1)-1:0]   cnt
);
    localparam int CW = $clog2(W + 1);

    // Sum the set bits of vec.
    always_comb begin
        // NOTE: the default comes first so no path through the block leaves cnt unassigned (no latch).
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end
endmodule

// File: rtl/partition_sweep_engine.sv
// Exhaustive sweep of 2^N_IN input vectors, comparing an exact and an approximate
// partition and accumulating mismatch count, Hamming sum, absolute-error sum and max error.
// Optional build macro: SWEEP_TRACE_EN (per-vector trace stream with back-pressure).
module partition_sweep_engine #(
    parameter int N_IN   = 7,
    parameter int N_OUT  = 4,
    parameter int SETTLE = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    partition_sweep_engine_if.slave bus
);
    import partition_sweep_pkg::*;

    localparam int ERR_W = err_cnt_w(N_IN);
    localparam int HAM_W = ham_sum_w(N_IN, N_OUT);
    localparam int ABS_W = abs_sum_w(N_IN, N_OUT);
    localparam int PC_W  = $clog2(N_OUT + 1);
    localparam int SW    = $clog2(SETTLE + 1);
    localparam int VW    = N_IN + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [VW-1:0] LAST_VEC    = VW'((2 ** N_IN) - 1);

    sweep_state_e     state, state_nxt;
    logic [VW-1:0]    vec_cnt;
    logic [SW-1:0]    settle_cnt;
    logic             done_r, aborted_r;
    logic [ERR_W-1:0] err_cnt_r;
    logic [HAM_W-1:0] ham_sum_r;
    logic [ABS_W-1:0] abs_sum_r;
    logic [N_OUT-1:0] max_err_r;

    logic [N_OUT-1:0] xor_vec;
    logic [PC_W-1:0]  ham_inc;
    logic [N_OUT:0]   diff;
    logic [N_OUT-1:0] abs_d;
    logic             fire;
    logic             last_vec;

    assign xor_vec  = bus.po_exact ^ bus.po_approx;
    assign diff     = {1'b0, bus.po_exact} - {1'b0, bus.po_approx};
    assign abs_d    = diff[N_OUT] ? N_OUT'(-diff) : N_OUT'(diff);
    assign last_vec = (vec_cnt == LAST_VEC);

    sweep_popcount #(.W(N_OUT)) u_popcount (
        .vec (xor_vec),
        .cnt (ham_inc)
    );

`ifdef SWEEP_TRACE_EN
    assign fire          = bus.trc_ready;
    assign bus.trc_valid = (state == CHECK);
    assign bus.trc_data  = (N_IN + 2 * N_OUT)'(pack_trace(32'(bus.pi), 32'(bus.po_exact),
                                                          32'(bus.po_approx), N_OUT));
`else
    assign fire = 1'b1;
`endif

    assign bus.pi      = vec_cnt[N_IN-1:0];
    assign bus.busy    = (state == APPLY) || (state == CHECK);
    assign bus.done    = done_r;
    assign bus.aborted = aborted_r;
    assign bus.err_cnt = err_cnt_r;
    assign bus.ham_sum = ham_sum_r;
    assign bus.abs_sum = abs_sum_r;
    assign bus.max_err = max_err_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: abort beats everything while busy, start only acts when idle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (bus.start) state_nxt = APPLY;
            APPLY: begin
                if (bus.abort)                       state_nxt = IDLE;
                else if (settle_cnt == SETTLE_LAST)  state_nxt = CHECK;
            end
            CHECK: begin
                if (bus.abort)   state_nxt = IDLE;
                else if (fire)   state_nxt = last_vec ? DONE : APPLY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector/settle counters, status flags and metric accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt    <= '0;
            settle_cnt <= '0;
            done_r     <= 1'b0;
            aborted_r  <= 1'b0;
            err_cnt_r  <= '0;
            ham_sum_r  <= '0;
            abs_sum_r  <= '0;
            max_err_r  <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        vec_cnt    <= '0;
                        settle_cnt <= '0;
                        aborted_r  <= 1'b0;
                        err_cnt_r  <= '0;
                        ham_sum_r  <= '0;
                        abs_sum_r  <= '0;
                        max_err_r  <= '0;
                    end
                end
                APPLY: begin
                    if (bus.abort)                      aborted_r  <= 1'b1;
                    else if (settle_cnt == SETTLE_LAST) settle_cnt <= '0;
                    else                                settle_cnt <= settle_cnt + SW'(1);
                end
                CHECK: begin
                    if (bus.abort) begin
                        aborted_r <= 1'b1;
                    end else if (fire) begin
                        err_cnt_r <= err_cnt_r + ERR_W'(xor_vec != '0);
                        ham_sum_r <= ham_sum_r + HAM_W'(ham_inc);
                        abs_sum_r <= abs_sum_r + ABS_W'(abs_d);
                        if (abs_d > max_err_r) max_err_r <= abs_d;
                        if (last_vec) done_r  <= 1'b1;
                        else          vec_cnt <= vec_cnt + VW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
